// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
// Holds the default sizes, the response-source encoding and the range check.
package dmem_pkg;

  localparam int unsigned MEM_WORDS_DEF    = 10000;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Word index is the byte address with the two low bits dropped.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned words);
    return (addr >> 2) < words;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Request, response and memory-side signals of the two-port data-memory arbiter.
// The slave side is the arbiter; the master side is the requesters plus the memory.
interface data_mem_arbiter_if;

  logic        A_Req;
  logic        A_We;
  logic [31:0] A_Addr;
  logic [31:0] A_WData;
  logic        A_Gnt;

  logic        B_Req;
  logic        B_We;
  logic [31:0] B_Addr;
  logic [31:0] B_WData;
  logic        B_Gnt;

  logic [31:0] RData;
  logic        RValid;
  logic        RSrc;
  logic        Err;

  logic [31:0] Mem_Address;
  logic [31:0] Mem_WriteData;
  logic        Mem_MemWrite;
  logic        Mem_MemRead;
  logic [31:0] Mem_ReadData;

  modport slave (
    input  A_Req, A_We, A_Addr, A_WData,
    input  B_Req, B_We, B_Addr, B_WData,
    output A_Gnt, B_Gnt,
    output RData, RValid, RSrc, Err,
    output Mem_Address, Mem_WriteData, Mem_MemWrite, Mem_MemRead,
    input  Mem_ReadData
  );

  modport master (
    output A_Req, A_We, A_Addr, A_WData,
    output B_Req, B_We, B_Addr, B_WData,
    input  A_Gnt, B_Gnt,
    input  RData, RValid, RSrc, Err,
    input  Mem_Address, Mem_WriteData, Mem_MemWrite, Mem_MemRead,
    output Mem_ReadData
  );

endinterface

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles port B was denied.
// Starve forces B ahead of A once the count reaches STARVE_LIMIT.
module dmem_starve_ctr
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic B_Req,
  input  logic B_Gnt,
  output logic Starve
);

  localparam int unsigned    CW    = $clog2(STARVE_LIMIT + 2);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!B_Req || B_Gnt) begin
      cnt_d = '0;
    end else if (cnt_q < LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Starve = (cnt_q >= LIMIT);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of an external word-addressed data memory.
// Port A (pipeline) wins by default; port B wins once it has starved long enough.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned MEM_WORDS    = MEM_WORDS_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  data_mem_arbiter_if.slave bus
);

  logic        starve;
  logic        a_gnt, b_gnt, any_gnt;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_we, sel_in_range;

  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        rsrc_q, rsrc_d;
  logic        err_q, err_d;

  assign a_gnt   = ~Reset & bus.A_Req & ~(bus.B_Req & starve);
  assign b_gnt   = ~Reset & bus.B_Req & (~bus.A_Req | starve);
  assign any_gnt = a_gnt | b_gnt;

  dmem_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .Clk    (Clk),
    .Reset  (Reset),
    .B_Req  (bus.B_Req),
    .B_Gnt  (b_gnt),
    .Starve (starve)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (a_gnt) begin
      sel_addr  = bus.A_Addr;
      sel_wdata = bus.A_WData;
      sel_we    = bus.A_We;
    end else if (b_gnt) begin
      sel_addr  = bus.B_Addr;
      sel_wdata = bus.B_WData;
      sel_we    = bus.B_We;
    end
  end

  assign sel_in_range = in_range(sel_addr, MEM_WORDS);

  assign bus.A_Gnt         = a_gnt;
  assign bus.B_Gnt         = b_gnt;
  assign bus.Mem_Address   = sel_addr & 32'hFFFF_FFFC;
  assign bus.Mem_WriteData = sel_wdata;
  assign bus.Mem_MemWrite  = any_gnt & sel_in_range & sel_we;
  assign bus.Mem_MemRead   = any_gnt & sel_in_range & ~sel_we;

  // Writes and out-of-range accesses still complete, but return zero data.
  always_comb begin
    rdata_d  = rdata_q;
    rsrc_d   = rsrc_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    if (any_gnt) begin
      rvalid_d = 1'b1;
      rsrc_d   = b_gnt ? SRC_B : SRC_A;
      err_d    = ~sel_in_range;
      rdata_d  = (sel_in_range && !sel_we) ? bus.Mem_ReadData : 32'h0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rsrc_q   <= SRC_A;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rsrc_q   <= rsrc_d;
      err_q    <= err_d;
    end
  end

  // Response outputs read as zero while Reset is held, so a grant just before reset never shows.
  assign bus.RData  = Reset ? 32'h0 : rdata_q;
  assign bus.RValid = ~Reset & rvalid_q;
  assign bus.RSrc   = ~Reset & rsrc_q;
  assign bus.Err    = ~Reset & err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural memory and a response scoreboard.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        src;
    logic        err;
  } resp_t;

  localparam int unsigned WORDS = 10000;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] mem [0:16383];
  resp_t       sb [$];
  logic [31:0] last_rdata;
  logic        last_src;

  data_mem_arbiter_if bus ();

  data_mem_arbiter dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.Mem_ReadData = mem[bus.Mem_Address[15:2]];

  always @(posedge clk) begin
    if (bus.Mem_MemWrite) mem[bus.Mem_Address[15:2]] <= bus.Mem_WriteData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check the previous cycle's response and this cycle's grant, queue the response.
  task automatic step(input bit r,
                      input bit ar, input bit aw, input logic [31:0] aa, input logic [31:0] ad,
                      input bit br, input bit bw, input logic [31:0] ba, input logic [31:0] bd,
                      input bit ega, input bit egb);
    resp_t       e;
    logic [31:0] addr, wd;
    logic        we, inr;
    rst = r;
    bus.A_Req = ar; bus.A_We = aw; bus.A_Addr = aa; bus.A_WData = ad;
    bus.B_Req = br; bus.B_We = bw; bus.B_Addr = ba; bus.B_WData = bd;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (r) e = '0;
      chk("rvalid", {31'b0, bus.RValid}, {31'b0, e.valid});
      chk("rdata",  bus.RData, e.rdata);
      chk("rsrc",   {31'b0, bus.RSrc}, {31'b0, e.src});
      chk("err",    {31'b0, bus.Err}, {31'b0, e.err});
    end
    chk("a_gnt", {31'b0, bus.A_Gnt}, {31'b0, ega});
    chk("b_gnt", {31'b0, bus.B_Gnt}, {31'b0, egb});
    addr = '0; wd = '0; we = 1'b0; inr = 1'b0;
    if (ega || egb) begin
      addr = ega ? aa : ba;
      wd   = ega ? ad : bd;
      we   = ega ? aw : bw;
      inr  = (addr >> 2) < WORDS;
    end
    chk("mem_addr",  bus.Mem_Address, {addr[31:2], 2'b00});
    chk("mem_wdata", bus.Mem_WriteData, wd);
    chk("mem_write", {31'b0, bus.Mem_MemWrite}, {31'b0, inr & we});
    chk("mem_read",  {31'b0, bus.Mem_MemRead}, {31'b0, inr & ~we});
    if (r) begin
      e = '0;
      last_rdata = '0;
      last_src   = 1'b0;
    end else if (ega || egb) begin
      e.valid = 1'b1;
      e.rdata = (inr && !we) ? mem[addr[15:2]] : 32'h0;
      e.src   = egb;
      e.err   = ~inr;
      last_rdata = e.rdata;
      last_src   = e.src;
    end else begin
      e = '{valid: 1'b0, rdata: last_rdata, src: last_src, err: 1'b0};
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    last_rdata = '0;
    last_src   = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'hA500_0000 | i;
    mem[16] = 32'hDEAD_BEEF;
    rst = 1'b1;
    bus.A_Req = 0; bus.A_We = 0; bus.A_Addr = 0; bus.A_WData = 0;
    bus.B_Req = 0; bus.B_We = 0; bus.B_Addr = 0; bus.B_WData = 0;
    @(negedge clk);

    // reset held with both requesting: no grants, memory side quiet
    step(1, 1, 0, 32'h40, 32'h0, 1, 0, 32'h48, 32'h0, 0, 0);
    step(1, 1, 0, 32'h40, 32'h0, 1, 0, 32'h48, 32'h0, 0, 0);

    // A read of word 0x10, then idle; low address bits ignored
    step(0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    idle();
    step(0, 1, 0, 32'h43, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    idle();

    // both requesting for 6 cycles: A x4, B, A
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 32'h44, 32'h0, 1, 0, 32'h48, 32'h0, 1, 0);
    step(0, 1, 0, 32'h44, 32'h0, 1, 0, 32'h48, 32'h0, 0, 1);
    step(0, 1, 0, 32'h44, 32'h0, 1, 0, 32'h48, 32'h0, 1, 0);
    idle();

    // B write then B read back
    step(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h1234_5678, 0, 1);
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, 0, 1);
    idle();

    // range boundary: index 10000 out, 9999 in, out-of-range write suppressed
    step(0, 1, 0, 32'h9C40, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 1, 0, 32'h9C3C, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    step(0, 1, 1, 32'h9C40, 32'hFFFF_FFFF, 0, 0, 32'h0, 32'h0, 1, 0);
    idle();

    // B alone three cycles, then contention shows the counter restarted from 0
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h48, 32'h0, 0, 1);
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 32'h44, 32'h0, 1, 0, 32'h4C, 32'h0, 1, 0);
    step(0, 1, 0, 32'h44, 32'h0, 1, 0, 32'h4C, 32'h0, 0, 1);
    idle();

    // A grant immediately followed by reset: response never appears
    step(0, 1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    step(1, 1, 0, 32'h40, 32'h0, 1, 1, 32'h48, 32'h5, 0, 0);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
